quet_hien_thi: RTL and testbench

- Time-multiplexed scan controller that shares one 7-segment decoder across N_DIGIT common-anode digits of the traffic-light countdown display.
- Holds shadow copies of the digit values and selects one digit per scan slot.
- Drives the decoder's 4-bit input and the active-low anode lines.
- Accepts new values from the light sequencer only at frame boundaries, through a req/ack handshake, so a displayed frame never tears.

---
 rtl/quet_hien_thi_pkg.sv | 15 +
 rtl/quet_hien_thi_if.sv | 27 ++
 rtl/quet_hien_thi_chia_tan.sv | 27 ++
 rtl/quet_hien_thi.sv | 84 ++++++++
 tb/tb_quet_hien_thi.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/quet_hien_thi_pkg.sv
// Shared constants for the countdown display scan controller.
package quet_hien_thi_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;
  localparam logic AN_OFF = 1'b1;

  // A tens digit showing zero is suppressed so "07" reads as " 7".
  function automatic logic tens_blank(input logic odd_slot,
                                      input logic [DIGIT_W-1:0] d,
                                      input logic lzb);
    return lzb && odd_slot && (d == '0);
  endfunction

endpackage

// File: rtl/quet_hien_thi_if.sv
// Sequencer-to-display bus: digit values, update handshake and scan outputs.
interface quet_hien_thi_if
  import quet_hien_thi_pkg::*;
#(
  parameter int N_DIGIT = 4
);

  logic                       en;
  logic [DIGIT_W*N_DIGIT-1:0] digit_in;
  logic                       lzb_en;
  logic                       upd_req;
  logic                       upd_ack;
  logic [0:DIGIT_W-1]         num;
  logic [N_DIGIT-1:0]         an;
  logic                       frame_done;

  modport master (
    output en, digit_in, lzb_en, upd_req,
    input  upd_ack, num, an, frame_done
  );

  modport slave (
    input  en, digit_in, lzb_en, upd_req,
    output upd_ack, num, an, frame_done
  );

endinterface

// File: rtl/quet_hien_thi_chia_tan.sv
// Slot prescaler: counts 0..SCAN_DIV-1, tick marks the last cycle of a slot.
module chia_tan #(
  parameter int SCAN_DIV = 50000,
  localparam int CW = $clog2(SCAN_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          tick
);

  localparam logic [CW-1:0] TOP = CW'(SCAN_DIV - 1);

  assign tick = (cnt == TOP);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/quet_hien_thi.sv
// Multiplexed scan controller for the traffic-light countdown digits,
// with frame-aligned shadow updates so a displayed frame never tears.
module quet_hien_thi
  import quet_hien_thi_pkg::*;
#(
  parameter int N_DIGIT   = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic           clk,
  input  logic           rst_n,
  quet_hien_thi_if.slave bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIGIT);
  localparam int SW = DIGIT_W * N_DIGIT;
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_DIGIT - 1);

  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_nx;
  logic               tick;
  logic               boundary;
  logic               cap;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      idx_nx;
  logic [SW-1:0]      shadow;
  logic [SW-1:0]      shadow_nx;
  logic [DIGIT_W-1:0] digit_nx;
  logic [DIGIT_W-1:0] num_nx;
  logic [N_DIGIT-1:0] an_nx;

  chia_tan #(.SCAN_DIV(SCAN_DIV)) u_chia_tan (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!bus.en),
    .cnt  (cnt),
    .tick (tick)
  );

  // Outputs are registered from next-state values, so cnt_nx repeats the
  // prescaler's own update rule to keep an/num aligned with the slot.
  always_comb begin
    boundary  = bus.en && tick && (idx == LAST_IDX);
    cap       = boundary && bus.upd_req;
    cnt_nx    = (!bus.en || tick) ? '0 : cnt + 1'b1;
    idx_nx    = idx;
    if (!bus.en) begin
      idx_nx = '0;
    end else if (tick) begin
      idx_nx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
    shadow_nx = cap ? bus.digit_in : shadow;
    digit_nx  = shadow_nx[int'(idx_nx)*DIGIT_W +: DIGIT_W];
    num_nx    = digit_nx;
    if (!bus.en || tens_blank(idx_nx[0], digit_nx, bus.lzb_en)) begin
      num_nx = BLANK_CODE;
    end
    an_nx = {N_DIGIT{AN_OFF}};
    if (bus.en && (cnt_nx >= BLANK_LIM)) begin
      an_nx[idx_nx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx            <= '0;
      shadow         <= {N_DIGIT{BLANK_CODE}};
      bus.an         <= {N_DIGIT{AN_OFF}};
      bus.num        <= BLANK_CODE;
      bus.upd_ack    <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      idx            <= idx_nx;
      shadow         <= shadow_nx;
      bus.an         <= an_nx;
      bus.num        <= num_nx;
      bus.upd_ack    <= cap;
      bus.frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_quet_hien_thi.sv
// Directed bench for quet_hien_thi with N_DIGIT=4, SCAN_DIV=4, BLANK_CYC=1.
module tb_quet_hien_thi;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] d2519 [4] = '{4'h9, 4'h1, 4'h5, 4'h2};
  logic [3:0] d1234 [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
  logic [3:0] d5678 [4] = '{4'h8, 4'h7, 4'h6, 4'h5};
  logic [3:0] d8642 [4] = '{4'h2, 4'h4, 4'h6, 4'h8};
  logic [3:0] lz_on [4] = '{4'h5, 4'hF, 4'h7, 4'hF};
  logic [3:0] lz_off[4] = '{4'h5, 4'h0, 4'h7, 4'h0};

  quet_hien_thi_if #(.N_DIGIT(4)) bus ();

  quet_hien_thi #(.N_DIGIT(4), .SCAN_DIV(4), .BLANK_CYC(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Edge k after a restart: slot k/4, position k%4; position 0 is the blank cycle.
  function automatic logic [3:0] exp_an(input int k);
    int c = k % 4;
    int s = (k / 4) % 4;
    return (c == 0) ? 4'b1111 : ~(4'b0001 << s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.upd_req  = 1'b0;
    bus.lzb_en   = 1'b0;
    bus.digit_in = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bus.an !== 4'b1111) begin
      miscompares++;
      $display("[TB] FAIL reset_an got %b want 1111", bus.an);
    end
    vectors++;
    if (bus.num !== 4'hF) begin
      miscompares++;
      $display("[TB] FAIL reset_num got %h want f", bus.num);
    end
    vectors++;
    if (bus.upd_ack !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ack got %b want 0", bus.upd_ack);
    end
    vectors++;
    if (bus.frame_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_frame_done got %b want 0", bus.frame_done);
    end
  endtask

  task automatic test_scan();
    do_reset();
    bus.en = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      vectors++;
      if (bus.an !== exp_an(k)) begin
        miscompares++;
        $display("[TB] FAIL scan_an k=%0d got %b want %b", k, bus.an, exp_an(k));
      end
      vectors++;
      if (bus.num !== 4'hF) begin
        miscompares++;
        $display("[TB] FAIL scan_num k=%0d got %h want f", k, bus.num);
      end
      vectors++;
      if (bus.frame_done !== (k % 16 == 0)) begin
        miscompares++;
        $display("[TB] FAIL scan_frame_done k=%0d got %b want %b", k, bus.frame_done, (k % 16 == 0));
      end
    end
  endtask

  task automatic test_update();
    logic [3:0] want;
    do_reset();
    bus.en = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      step();
      want = (k < 16) ? 4'hF : d2519[(k / 4) % 4];
      vectors++;
      if (bus.upd_ack !== (k == 16)) begin
        miscompares++;
        $display("[TB] FAIL update_ack k=%0d got %b want %b", k, bus.upd_ack, (k == 16));
      end
      vectors++;
      if (bus.num !== want) begin
        miscompares++;
        $display("[TB] FAIL update_num k=%0d got %h want %h", k, bus.num, want);
      end
      vectors++;
      if (bus.an !== exp_an(k)) begin
        miscompares++;
        $display("[TB] FAIL update_an k=%0d got %b want %b", k, bus.an, exp_an(k));
      end
      if (k == 5) begin
        bus.upd_req  = 1'b1;
        bus.digit_in = 16'h2519;
      end
      if (k == 16) bus.upd_req = 1'b0;
    end
  endtask

  task automatic test_lzb();
    logic [3:0] want;
    do_reset();
    bus.en       = 1'b1;
    bus.lzb_en   = 1'b1;
    bus.upd_req  = 1'b1;
    bus.digit_in = 16'h0705;
    for (int k = 1; k <= 47; k++) begin
      step();
      if (k < 16)      want = 4'hF;
      else if (k < 32) want = lz_on[(k / 4) % 4];
      else             want = lz_off[(k / 4) % 4];
      vectors++;
      if (bus.num !== want) begin
        miscompares++;
        $display("[TB] FAIL lzb_num k=%0d got %h want %h", k, bus.num, want);
      end
      if (k == 16) bus.upd_req = 1'b0;
      if (k == 31) bus.lzb_en = 1'b0;
    end
  endtask

  task automatic test_enable();
    do_reset();
    bus.en       = 1'b1;
    bus.upd_req  = 1'b1;
    bus.digit_in = 16'h2519;
    for (int k = 1; k <= 26; k++) begin
      step();
      if (k == 16) bus.upd_req = 1'b0;
    end
    vectors++;
    if (bus.an !== 4'b1011) begin
      miscompares++;
      $display("[TB] FAIL enable_pre_an got %b want 1011", bus.an);
    end
    bus.en = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      step();
      vectors++;
      if (bus.an !== 4'b1111 || bus.num !== 4'hF) begin
        miscompares++;
        $display("[TB] FAIL enable_off j=%0d got an=%b num=%h want an=1111 num=f", j, bus.an, bus.num);
      end
      vectors++;
      if (bus.frame_done !== 1'b0 || bus.upd_ack !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL enable_off_pulse j=%0d got fd=%b ack=%b want 0 0", j, bus.frame_done, bus.upd_ack);
      end
    end
    bus.en = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      step();
      vectors++;
      if (bus.an !== exp_an(j)) begin
        miscompares++;
        $display("[TB] FAIL enable_resume_an j=%0d got %b want %b", j, bus.an, exp_an(j));
      end
      vectors++;
      if (bus.num !== d2519[(j / 4) % 4]) begin
        miscompares++;
        $display("[TB] FAIL enable_resume_num j=%0d got %h want %h", j, bus.num, d2519[(j / 4) % 4]);
      end
      vectors++;
      if (bus.frame_done !== (j == 16)) begin
        miscompares++;
        $display("[TB] FAIL enable_resume_fd j=%0d got %b want %b", j, bus.frame_done, (j == 16));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.en       = 1'b1;
    bus.upd_req  = 1'b1;
    bus.digit_in = 16'h1234;
    for (int k = 1; k <= 47; k++) begin
      step();
      vectors++;
      if (bus.upd_ack !== (k == 16 || k == 32)) begin
        miscompares++;
        $display("[TB] FAIL b2b_ack k=%0d got %b want %b", k, bus.upd_ack, (k == 16 || k == 32));
      end
      if (k >= 16 && k < 32) begin
        vectors++;
        if (bus.num !== d1234[(k / 4) % 4]) begin
          miscompares++;
          $display("[TB] FAIL b2b_num1 k=%0d got %h want %h", k, bus.num, d1234[(k / 4) % 4]);
        end
      end
      if (k >= 32) begin
        vectors++;
        if (bus.num !== d5678[(k / 4) % 4]) begin
          miscompares++;
          $display("[TB] FAIL b2b_num2 k=%0d got %h want %h", k, bus.num, d5678[(k / 4) % 4]);
        end
      end
      if (k == 16) bus.digit_in = 16'h5678;
      if (k == 32) bus.upd_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] want;
    do_reset();
    bus.en       = 1'b1;
    bus.upd_req  = 1'b1;
    bus.digit_in = 16'h2519;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k == 16) bus.upd_req = 1'b0;
    end
    bus.upd_req  = 1'b1;
    bus.digit_in = 16'h8642;
    rst_n        = 1'b0;
    step();
    rst_n = 1'b1;
    vectors++;
    if (bus.an !== 4'b1111 || bus.num !== 4'hF) begin
      miscompares++;
      $display("[TB] FAIL midreset_out got an=%b num=%h want an=1111 num=f", bus.an, bus.num);
    end
    vectors++;
    if (bus.upd_ack !== 1'b0 || bus.frame_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_pulse got ack=%b fd=%b want 0 0", bus.upd_ack, bus.frame_done);
    end
    for (int j = 1; j <= 20; j++) begin
      step();
      want = (j < 16) ? 4'hF : d8642[(j / 4) % 4];
      vectors++;
      if (bus.upd_ack !== (j == 16)) begin
        miscompares++;
        $display("[TB] FAIL midreset_ack j=%0d got %b want %b", j, bus.upd_ack, (j == 16));
      end
      vectors++;
      if (bus.num !== want) begin
        miscompares++;
        $display("[TB] FAIL midreset_num j=%0d got %h want %h", j, bus.num, want);
      end
      if (j == 16) bus.upd_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_update();
    test_lzb();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
